// File: rtl/fpio_pkg.sv
// fpio_pkg: shared types and helpers for the fpio nibble link.
package fpio_pkg;

  localparam int unsigned FPIO_DATA_WIDTH = 4;
  localparam int unsigned FPIO_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2
  } fpio_tx_state_e;

  // Number of beats needed to carry one word.
  function automatic int unsigned fpio_nbeats(input int unsigned word_w, input int unsigned data_w);
    return word_w / data_w;
  endfunction

endpackage

// File: rtl/fpio_if.sv
// fpio_if: narrow beat link; DAT/DAT_v flow forward, DAT_r is far-end backpressure.
interface fpio_if
  import fpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FPIO_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] DAT;
  logic                  DAT_v;
  logic                  DAT_r;

  modport xmit (output DAT, output DAT_v, input DAT_r);
  modport recv (input DAT, input DAT_v, output DAT_r);
endinterface

// File: rtl/fpio_word_tx.sv
// fpio_word_tx: serialises WORD_WIDTH-bit words into DATA_WIDTH-bit beats, LSB beat
// first, onto the fpio_if transmit side, honouring DAT_r backpressure.
// Build option: define FPIO_WORD_TX_PARITY_EN to append an XOR parity beat per word.
module fpio_word_tx
  import fpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FPIO_DATA_WIDTH,
  parameter int unsigned WORD_WIDTH = FPIO_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] w_dat,
  input  logic                  w_valid,
  output logic                  w_ready,
  fpio_if.xmit                  tx
);

  localparam int unsigned NBEATS = fpio_nbeats(WORD_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W  = (NBEATS > 2) ? $clog2(NBEATS) : 1;
  localparam int unsigned REST_W = WORD_WIDTH - DATA_WIDTH;

  // Reject word/beat geometries the serialiser cannot handle.
  if (((WORD_WIDTH % DATA_WIDTH) != 0) || (NBEATS < 2)) begin : g_cfg_check
    $error("fpio_word_tx: WORD_WIDTH must be a multiple of DATA_WIDTH and at least 2*DATA_WIDTH");
  end

  fpio_tx_state_e        state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REST_W-1:0]     shift_q;   // beats still to be presented after the current one
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  dat_v_q;
`ifdef FPIO_WORD_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] par_q;     // running XOR of the beats presented so far
`endif

  logic last_beat;
  logic beat_xfer;
  logic word_xfer;

  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
  assign beat_xfer = dat_v_q && tx.DAT_r;

  // Word acceptance: idle, or the final beat of the current word leaving this cycle.
`ifdef FPIO_WORD_TX_PARITY_EN
  assign w_ready = !reset && ((state_q == IDLE) || ((state_q == PARITY) && tx.DAT_r));
`else
  assign w_ready = !reset && ((state_q == IDLE) || ((state_q == SEND) && last_beat && tx.DAT_r));
`endif
  assign word_xfer = w_valid && w_ready;

  assign tx.DAT   = dat_q;
  assign tx.DAT_v = dat_v_q;

  // Beat sequencer: load on word accept, shift on beat transfer, hold under backpressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dat_q   <= '0;
      dat_v_q <= 1'b0;
`ifdef FPIO_WORD_TX_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (word_xfer) begin
            state_q <= SEND;
            cnt_q   <= '0;
            shift_q <= w_dat[WORD_WIDTH-1:DATA_WIDTH];
            dat_q   <= w_dat[DATA_WIDTH-1:0];
            dat_v_q <= 1'b1;
`ifdef FPIO_WORD_TX_PARITY_EN
            par_q   <= w_dat[DATA_WIDTH-1:0];
`endif
          end
        end
        SEND: begin
          if (beat_xfer) begin
            if (!last_beat) begin
              cnt_q   <= cnt_q + CNT_W'(1);
              dat_q   <= shift_q[DATA_WIDTH-1:0];
              shift_q <= shift_q >> DATA_WIDTH;
`ifdef FPIO_WORD_TX_PARITY_EN
              par_q   <= par_q ^ shift_q[DATA_WIDTH-1:0];
`endif
            end else begin
`ifdef FPIO_WORD_TX_PARITY_EN
              state_q <= PARITY;
              dat_q   <= par_q;
`else
              if (word_xfer) begin
                cnt_q   <= '0;
                shift_q <= w_dat[WORD_WIDTH-1:DATA_WIDTH];
                dat_q   <= w_dat[DATA_WIDTH-1:0];
              end else begin
                state_q <= IDLE;
                dat_v_q <= 1'b0;
              end
`endif
            end
          end
        end
`ifdef FPIO_WORD_TX_PARITY_EN
        PARITY: begin
          if (beat_xfer) begin
            if (word_xfer) begin
              state_q <= SEND;
              cnt_q   <= '0;
              shift_q <= w_dat[WORD_WIDTH-1:DATA_WIDTH];
              dat_q   <= w_dat[DATA_WIDTH-1:0];
              par_q   <= w_dat[DATA_WIDTH-1:0];
            end else begin
              state_q <= IDLE;
              dat_v_q <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          dat_v_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
